npu_regfile_mp: RTL and testbench
=================================

# npu_regfile_mp

Parametrised multi-port register file with registered reads, write-first bypass and a per-register busy scoreboard. It is the next-generation replacement for the single-write/dual-read file in the NPU scalar/control datapath. Issue logic reserves destination registers, writeback clears them, and readers get data plus a busy flag, one cycle after request.

## Interface
- `DATA_WIDTH`, default 32: register width in bits.
- `NUM_REGS`, default 32: number of registers (≥2).
- `NUM_WR`, default 2: write ports (1–4).
- `NUM_RD`, default 3: read ports (1–8).
- `ZERO_REG0`, default 1: if 1, register 0 reads as 0; writes and reservations to it are ignored.
- `ADDR_WIDTH`, default $clog2(NUM_REGS): address width.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  [NUM_WR]: per-port write enable.
- `wr_addr`  in  [NUM_WR][ADDR_WIDTH]: write address.
- `wr_data`  in  [NUM_WR][DATA_WIDTH]: write data.
- `rd_en`  in  [NUM_RD]: per-port read request.
- `rd_addr`  in  [NUM_RD][ADDR_WIDTH]: read address.
- `rd_data`  out  [NUM_RD][DATA_WIDTH]: registered read data.
- `rd_valid`  out  [NUM_RD]: rd_data/rd_busy are valid this cycle.
- `rd_busy`  out  [NUM_RD]: addressed register was pending at the request edge.
- `rsv_en`  in  1: reserve a destination register (mark busy).
- `rsv_addr`  in  ADDR_WIDTH: register to reserve.
- `busy_vec`  out  NUM_REGS: current scoreboard state.
- `wr_conflict`  out  1: registered pulse; two or more enabled write ports targeted the same address last cycle.

## Operation
- Reset (`rst`=1 at an edge): all registers are 0; busy_vec, rd_data, rd_valid, rd_busy and wr_conflict are 0. Reset mid-operation discards in-flight reads (rd_valid=0 in the next cycle) and all reservations.
- Write: for each enabled port, register[wr_addr] <= wr_data at the edge. If several ports target the same address, the highest port index wins and wr_conflict=1 in the following cycle.
- Read: when rd_en[i] is sampled at edge N, rd_data[i]/rd_busy[i] are presented with rd_valid[i]=1 after edge N. When rd_en[i]=0, rd_valid[i]=0 and rd_data[i] holds its last value.
- Bypass (write-first): a read and an enabled write to the same address in the same cycle returns the new write data, using the winning port's data.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - Any enabled write to address a clears busy[a].
  - Reserve and write to the same address in the same cycle leave busy set, because the reserve belongs to the newer producer.
- rd_busy[i] is the post-update busy state of the read address. A read that coincides with the clearing write therefore returns busy=0 and the fresh data.
- ZERO_REG0=1: address 0 reads 0, and rd_busy is always 0 for it. Writes to address 0 are dropped but still counted for wr_conflict. rsv_en to address 0 is ignored.
- Out-of-range addresses (NUM_REGS not a power of 2): writes and reserves are dropped; reads return 0 with busy=0.

## Timing
- Read latency: exactly 1 cycle from request to rd_valid. Full throughput: a new read per port every cycle.
- Write latency: visible to a same-cycle read via bypass and to all later reads.
- Scoreboard latency: busy_vec reflects reserve/clear 1 cycle after the request edge.
- No stalls and no backpressure; all ports are independent.

## Structure
- Shared package `npu_rf_pkg`:
  - default widths and counts as localparams;
  - typedef `rf_addr_t`;
  - function `rf_wr_winner` (highest-index match resolver), reused by the bypass and storage paths.
- Sub-module `npu_rf_scoreboard`: busy vector, set/clear priority and the per-port busy lookup.
- Storage array, bypass muxes and output registers stay in the top module.

## Test plan
- Reset then read: reset, then read regs 0..31 on all ports → every rd_data=0, rd_busy=0, rd_valid=1 one cycle after each request.
- Bypass: same cycle, write port 0 reg 5 = 0xDEADBEEF and read port 2 reg 5 → next cycle rd_data[2]=0xDEADBEEF.
- Write conflict: port 0 writes reg 7 = 0x11 and port 1 writes reg 7 = 0x22 in the same cycle → next cycle wr_conflict=1; a later read of reg 7 returns 0x22.
- Scoreboard: reserve reg 9, then read reg 9 → rd_busy=1. Write reg 9 = 0x5A while reading it → rd_busy=0, rd_data=0x5A, busy_vec[9]=0.
- Reserve/write collision: rsv reg 3 and write reg 3 in the same cycle → busy_vec[3]=1 afterward and the data is updated.
- Zero reg and reset mid-op: write 0xFF to reg 0 → reads return 0. Assert rst while a read is in flight → rd_valid=0 and busy_vec=0 next cycle.

Source files
------------

// File: rtl/npu_rf_pkg.sv
// npu_rf_pkg: shared definitions for the NPU multi-port register file.
//   - default widths/counts (RF_*)
//   - rf_addr_t    : register address at default sizing
//   - rf_win_t     : write-port resolution result (hit + winning port index)
//   - rf_wr_winner : highest-index match resolver, shared by the storage
//                    update and the read bypass so both agree on the winner
package npu_rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_NUM_WR   = 2;
  localparam int RF_NUM_RD   = 3;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
  localparam int RF_MAX_WR   = 4;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rf_win_t;

  // match[p] = write port p is enabled and targets the address of interest.
  // Later ports overwrite earlier ones, so the highest index wins.
  function automatic rf_win_t rf_wr_winner(input logic [RF_MAX_WR-1:0] match);
    rf_win_t w;
    w = '0;
    for (int p = 0; p < RF_MAX_WR; p++) begin
      if (match[p]) begin
        w.hit = 1'b1;
        w.idx = p[1:0];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/npu_rf_scoreboard.sv
// npu_rf_scoreboard: per-register busy bits for the NPU register file.
//   clk, rst           : clock, synchronous active-high reset
//   rsv_en, rsv_addr   : reserve (set busy) a destination register
//   wr_en, wr_addr     : writeback ports; any enabled write clears busy
//   rd_addr            : read addresses to look up
//   busy_vec           : registered scoreboard state
//   rd_busy_nxt        : post-update busy of each read address (comb),
//                        registered by the top alongside read data
module npu_rf_scoreboard
  import npu_rf_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_WR     = RF_NUM_WR,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int ZERO_REG0  = 1,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rsv_en,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr,
  input  logic [NUM_WR-1:0]                   wr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_REGS-1:0]                 busy_vec,
  output logic [NUM_RD-1:0]                   rd_busy_nxt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Reserve beats clear: a reserve landing with a writeback to the same
  // register belongs to the newer producer, so the bit must stay set.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic set_r, clr_r;
      set_r = rsv_en && (rsv_addr == ADDR_WIDTH'(r)) && !((ZERO_REG0 != 0) && (r == 0));
      clr_r = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && (wr_addr[p] == ADDR_WIDTH'(r))) clr_r = 1'b1;
      busy_d[r] = set_r | (busy_q[r] & ~clr_r);
    end
  end

  // Lookup uses the next state so a read that meets its clearing write
  // reports not-busy together with the bypassed data.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_nxt[i] = 1'b0;
      if (32'(rd_addr[i]) < 32'(NUM_REGS)) rd_busy_nxt[i] = busy_d[rd_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/npu_regfile_mp.sv
// npu_regfile_mp: multi-port register file, registered reads, write-first
// bypass, per-register busy scoreboard.
//   clk, rst                    : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data       : NUM_WR write ports (highest index wins)
//   rd_en/rd_addr               : NUM_RD read requests
//   rd_data/rd_valid/rd_busy    : read response, one cycle after request
//   rsv_en/rsv_addr             : reserve a destination register
//   busy_vec                    : scoreboard state
//   wr_conflict                 : pulse, same-address multi-port write last cycle
module npu_regfile_mp
  import npu_rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_WR     = RF_NUM_WR,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int ZERO_REG0  = 1,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_WR-1:0]                   wr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_RD-1:0]                   rd_en,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]                   rd_valid,
  output logic [NUM_RD-1:0]                   rd_busy,
  input  logic                                rsv_en,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr,
  output logic [NUM_REGS-1:0]                 busy_vec,
  output logic                                wr_conflict
);

  // Selects the winning port's data; a loop avoids indexing wr_data with
  // the fixed 2-bit winner index when NUM_WR is smaller than 4.
  function automatic logic [DATA_WIDTH-1:0] wsel(
    input logic [NUM_WR-1:0][DATA_WIDTH-1:0] d,
    input logic [1:0]                        idx
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (idx == p[1:0]) v = d[p];
    return v;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_nxt [NUM_RD];
  logic [NUM_RD-1:0]     rd_busy_nxt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_RD-1:0]     rd_valid_q, rd_busy_q;
  logic                  wr_conflict_q, wr_conflict_d;

  // Storage update; register 0 is never written when hardwired to zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic [RF_MAX_WR-1:0] m;
      rf_win_t              w;
      m = '0;
      for (int p = 0; p < NUM_WR; p++)
        m[p] = wr_en[p] && (wr_addr[p] == ADDR_WIDTH'(r));
      w = rf_wr_winner(m);
      mem_d[r] = mem_q[r];
      if (w.hit && !((ZERO_REG0 != 0) && (r == 0))) mem_d[r] = wsel(wr_data, w.idx);
    end
  end

  // Raw address compare: writes to reg 0 still count as conflicts.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (wr_en[p] && wr_en[q] && (wr_addr[p] == wr_addr[q])) wr_conflict_d = 1'b1;
  end

  // Per-port read mux: out-of-range / zero reg -> 0, else bypass, else array.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    always_comb begin
      logic [RF_MAX_WR-1:0] m;
      rf_win_t              w;
      logic                 in_rng, is_zero;
      m = '0;
      for (int p = 0; p < NUM_WR; p++)
        m[p] = wr_en[p] && (wr_addr[p] == rd_addr[gi]);
      w       = rf_wr_winner(m);
      in_rng  = 32'(rd_addr[gi]) < 32'(NUM_REGS);
      is_zero = (ZERO_REG0 != 0) && (rd_addr[gi] == '0);
      if (!in_rng || is_zero) rd_nxt[gi] = '0;
      else if (w.hit)         rd_nxt[gi] = wsel(wr_data, w.idx);
      else                    rd_nxt[gi] = mem_q[rd_addr[gi]];
    end
  end

  npu_rf_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .NUM_WR     (NUM_WR),
    .NUM_RD     (NUM_RD),
    .ZERO_REG0  (ZERO_REG0),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .busy_vec    (busy_vec),
    .rd_busy_nxt (rd_busy_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  // Data/busy hold when the port is idle; valid is a one-deep pipe of rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      rd_busy_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
      rd_valid_q    <= rd_en;
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_data_q[i] <= rd_nxt[i];
          rd_busy_q[i] <= rd_busy_nxt[i];
        end
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_busy     = rd_busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_npu_regfile_mp.sv
module tb_npu_regfile_mp;
  import npu_rf_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NW = 2;
  localparam int ND = 3;
  localparam int AW = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][AW-1:0]  wr_addr;
  logic [NW-1:0][DW-1:0]  wr_data;
  logic [ND-1:0]          rd_en;
  logic [ND-1:0][AW-1:0]  rd_addr;
  logic [ND-1:0][DW-1:0]  rd_data;
  logic [ND-1:0]          rd_valid;
  logic [ND-1:0]          rd_busy;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NR-1:0]          busy_vec;
  logic                   wr_conflict;

  int checks = 0;
  int failures = 0;

  npu_regfile_mp dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rf_addr_t a;
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid",    64'(rd_valid), 64'h0);
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_conflict", 64'(wr_conflict), 64'h0);
    chk("rst_rd_data",  64'(rd_data[0] | rd_data[1] | rd_data[2]), 64'h0);

    // Every register reads 0 on every port after reset.
    for (int r = 0; r < NR; r++) begin
      a = rf_addr_t'(r);
      rd_en = 3'b111; rd_addr = {a, a, a};
      tick();
      chk("sweep_valid", 64'(rd_valid), 64'h7);
      chk("sweep_data",  64'(rd_data[0] | rd_data[1] | rd_data[2]), 64'h0);
      chk("sweep_busy",  64'(rd_busy), 64'h0);
    end
    idle(); tick();
    chk("idle_valid", 64'(rd_valid), 64'h0);

    // Bypass: write reg5 on port 0 while port 2 reads it.
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    rd_en = 3'b100; rd_addr[2] = 5'd5;
    tick();
    chk("byp_data",  64'(rd_data[2]), 64'hDEADBEEF);
    chk("byp_valid", 64'(rd_valid), 64'h4);
    chk("byp_noconf", 64'(wr_conflict), 64'h0);
    idle();

    // Conflict on reg7: port 1 wins, also through the bypass on read port 1.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_en = 3'b010; rd_addr[1] = 5'd7;
    tick();
    chk("conf_flag", 64'(wr_conflict), 64'h1);
    chk("conf_byp",  64'(rd_data[1]), 64'h22);
    idle();
    rd_en = 3'b001; rd_addr[0] = 5'd7;
    tick();
    chk("conf_read",  64'(rd_data[0]), 64'h22);
    chk("conf_clear", 64'(wr_conflict), 64'h0);
    idle();

    // Distinct addresses on both ports: no conflict, both stored.
    wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hB, 32'hA};
    tick();
    chk("noconf_flag", 64'(wr_conflict), 64'h0);
    idle();
    rd_en = 3'b111; rd_addr = {5'd5, 5'd11, 5'd10};
    tick();
    chk("rd_p0", 64'(rd_data[0]), 64'hA);
    chk("rd_p1", 64'(rd_data[1]), 64'hB);
    chk("rd_p2", 64'(rd_data[2]), 64'hDEADBEEF);
    idle();

    // Scoreboard: reserve 9, read busy, then clearing write with read.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    chk("rsv9_vec", 64'(busy_vec), 64'h200);
    idle();
    rd_en = 3'b001; rd_addr[0] = 5'd9;
    tick();
    chk("rsv9_rdbusy", 64'(rd_busy[0]), 64'h1);
    idle();
    wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h5A;
    rd_en = 3'b001; rd_addr[0] = 5'd9;
    tick();
    chk("clr9_rdbusy", 64'(rd_busy[0]), 64'h0);
    chk("clr9_data",   64'(rd_data[0]), 64'h5A);
    chk("clr9_vec",    64'(busy_vec), 64'h0);
    idle();

    // Reserve and write reg3 together: stays busy, data updated.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
    tick();
    chk("rw3_vec", 64'(busy_vec), 64'h8);
    idle();
    rd_en = 3'b010; rd_addr[1] = 5'd3;
    tick();
    chk("rw3_data", 64'(rd_data[1]), 64'h33);
    chk("rw3_busy", 64'(rd_busy[1]), 64'h1);
    idle();

    // Reserve and read reg12 together: read sees post-update busy.
    // Port 0 idle: its data holds the earlier 0x5A.
    rsv_en = 1'b1; rsv_addr = 5'd12;
    rd_en = 3'b100; rd_addr[2] = 5'd12;
    tick();
    chk("rsv12_rdbusy", 64'(rd_busy[2]), 64'h1);
    chk("rsv12_vec",    64'(busy_vec), 64'h1008);
    chk("hold_p0",      64'(rd_data[0]), 64'h5A);
    chk("hold_valid",   64'(rd_valid), 64'h4);
    idle();

    // Zero register: write, reserve and bypass read all stay 0.
    wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'hFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_en = 3'b001; rd_addr[0] = 5'd0;
    tick();
    chk("z_byp",  64'(rd_data[0]), 64'h0);
    chk("z_busy", 64'(rd_busy[0]), 64'h0);
    chk("z_vec",  64'(busy_vec), 64'h1008);
    idle();
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFF, 32'hEE};
    tick();
    chk("z_conf", 64'(wr_conflict), 64'h1);
    idle();
    rd_en = 3'b010; rd_addr[1] = 5'd0;
    tick();
    chk("z_read", 64'(rd_data[1]), 64'h0);
    idle();

    // Reset with reads in flight.
    rd_en = 3'b111; rd_addr = {5'd12, 5'd5, 5'd3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_valid", 64'(rd_valid), 64'h0);
    chk("mrst_vec",   64'(busy_vec), 64'h0);
    chk("mrst_data",  64'(rd_data[0] | rd_data[1] | rd_data[2]), 64'h0);
    rd_en = 3'b001; rd_addr[0] = 5'd5;
    tick();
    chk("mrst_reg5",   64'(rd_data[0]), 64'h0);
    chk("mrst_valid2", 64'(rd_valid), 64'h1);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
